reg_file_mp: RTL
================

// Module: reg_file_mp
// PURPOSE
//   Parametrised multi-port integer register file for the RISC-V softcore.
//   - Successor to the 2R1W reg_file: configurable XLEN, register count, read/write port counts.
//   - Adds an optional registered read stage, write-to-read bypass, synchronous clear and a hardwired-zero x0.
//   - Sits between decode (read addresses) and writeback (write ports); feeds ALU/branch operands.
// PARAMETERS
//   XLEN      32  data width in bits
//   NREGS     32  number of architectural registers, power of two >= 2
//   AW        5   address width, = log2(NREGS)
//   NR        2   number of read ports, 1..4
//   NW        1   number of write ports, 1..2
//   READ_LAT  0   0: combinational read; 1: read data registered on posedge clk
//   BYPASS    1   1: a same-cycle write is visible on a matching read; 0: old value returned
//   ZERO_R0   1   1: register 0 reads 0 and ignores writes
// PORTS
//   clk    in   1        clock; all state updates on rising edge
//   rst_n  in   1        asynchronous active-low reset
//   clr    in   1        synchronous clear of all registers
//   we     in   NW       write enable per write port
//   waddr  in   NW*AW    write addresses; port k at [k*AW +: AW]
//   wdata  in   NW*XLEN  write data; port k at [k*XLEN +: XLEN]
//   raddr  in   NR*AW    read addresses; port j at [j*AW +: AW]
//   rdata  out  NR*XLEN  read data; port j at [j*XLEN +: XLEN]
// BEHAVIOUR
//   Reset
//     - rst_n low (asynchronous) clears all NREGS registers to 0.
//     - If READ_LAT=1, it also clears every rdata pipeline register to 0.
//     - Reset mid-write: the write is discarded.
//     - First write honoured is at the first rising edge after rst_n deasserts.
//   Write (posedge)
//     - Port k with we[k]=1 stores wdata[k] into waddr[k].
//     - ZERO_R0=1: writes to address 0 are ignored.
//     - NW=2, both ports to the same address: port 1 wins.
//     - clr=1 zeroes all registers and overrides every write in that cycle.
//   Read, READ_LAT=0
//     - rdata[j] combinationally equals reg[raddr[j]].
//     - BYPASS=1 and a live write to raddr[j] (we=1, clr=0, addr!=0 when ZERO_R0): rdata[j] = that wdata.
//     - Bypass uses the highest-numbered matching write port.
//     - Under clr with BYPASS=1, rdata = 0.
//   Read, READ_LAT=1
//     - raddr sampled at posedge t; rdata valid after edge t, held until the next edge.
//     - Captured value is the post-write value if BYPASS=1, the pre-write value if BYPASS=0.
//     - clr at edge t captures 0 when BYPASS=1.
//   Address 0 with ZERO_R0=1: rdata = 0 always, including under bypass.
//   Ports are independent; any number of read ports may hit the same address.
//   No handshake: one write per port per cycle, reads every cycle.
//   Latency: write-to-architectural state is 1 cycle; read is 0 or 1 cycle per READ_LAT.
// STRUCTURE
//   Shared package rf_pkg:
//     - RF_XLEN, RF_NREGS, RF_AW defaults
//     - READ_LAT_COMB / READ_LAT_REG encodings
//     - function clog2
//   Sub-module rf_read_port: address mux, bypass compare/select and the optional output register.
//   Top-level instances: NR x rf_read_port via generate loop.
//   Register array lives in the top level as flip-flops, not a RAM macro; async reset requires FFs.
// TESTING
//   1. Reset: rst_n=0 for 2 cycles, then read all 32 addresses -> every rdata = 0.
//   2. Basic write/read: write x1=AAAA_AAAA, x2=5555_5555, then raddr0=1, raddr1=2 -> rdata0=AAAA_AAAA, rdata1=5555_5555.
//   3. x0: write x0=FFFF_FFFF, then read x0 on both ports -> 0; with BYPASS=1 in the same cycle -> still 0.
//   4. Bypass, READ_LAT=0: we=1, waddr=3, wdata=1234_5678 and raddr0=3 in the same cycle.
//      - BYPASS=1 -> rdata0 = 1234_5678 before the edge.
//      - BYPASS=0 -> rdata0 = old x3.
//   5. Dual write, NW=2: both ports write x5 with 1111_1111 (port 0) and 2222_2222 (port 1) -> x5 = 2222_2222.
//      Then READ_LAT=1, raddr0=5 -> 2222_2222 appears one cycle later.
//   6. clr and mid-op reset:
//      - clr=1 together with a write x7=DEAD_BEEF -> x7 = 0 and all registers = 0.
//      - Write x8=CAFE_F00D, then rst_n pulsed low between edges -> x8 = 0 immediately; registered rdata = 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port integer register file.
//   RF_XLEN / RF_NREGS / RF_AW : default geometry (32 x 32-bit, 5-bit addresses)
//   READ_LAT_COMB / READ_LAT_REG : encodings for the READ_LAT parameter
//   clog2 : ceiling log2, used to derive the address width from NREGS
package rf_pkg;
  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;
  localparam int RF_AW    = 5;

  localparam int READ_LAT_COMB = 0;
  localparam int READ_LAT_REG  = 1;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction
endpackage

// File: rtl/rf_read_port.sv
// One read port of reg_file_mp.
//   clk, rst_n : clock / async active-low reset (output register only)
//   clr        : synchronous clear in progress this cycle
//   wlive      : per write port, write will actually land this edge
//   wa, wd     : per write port address / data
//   regs       : current architectural register contents
//   raddr      : read address
//   rdata      : read data (combinational or registered per READ_LAT)
module rf_read_port import rf_pkg::*; #(
  parameter int XLEN     = RF_XLEN,
  parameter int NREGS    = RF_NREGS,
  parameter int AW       = RF_AW,
  parameter int NW       = 1,
  parameter int READ_LAT = READ_LAT_COMB,
  parameter int BYPASS   = 1,
  parameter int ZERO_R0  = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic [NW-1:0]                    wlive,
  input  logic [NW-1:0][AW-1:0]            wa,
  input  logic [NW-1:0][XLEN-1:0]          wd,
  input  logic [NREGS-1:0][XLEN-1:0]       regs,
  input  logic [AW-1:0]                    raddr,
  output logic [XLEN-1:0]                  rdata
);
  logic [XLEN-1:0] val;
  logic [XLEN-1:0] rdata_d, rdata_q;

  // With bypass the selected value equals the post-edge register contents,
  // so the same mux serves both the combinational read and the value the
  // registered read captures.
  always_comb begin
    val = regs[raddr];
    if (BYPASS != 0) begin
      if (clr) begin
        val = '0;
      end else begin
        // later ports overwrite earlier ones: highest matching port wins
        for (int k = 0; k < NW; k++) begin
          if (wlive[k] && (wa[k] == raddr)) val = wd[k];
        end
      end
    end
    if ((ZERO_R0 != 0) && (raddr == '0)) val = '0;
  end

  assign rdata_d = val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  // In the combinational configuration the flop has no load and is trimmed.
  assign rdata = (READ_LAT == READ_LAT_REG) ? rdata_q : val;
endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port integer register file (flip-flop array).
//   clk, rst_n : clock / async active-low reset (clears all registers)
//   clr        : synchronous clear; overrides every write that cycle
//   we         : [NW] write enables
//   waddr      : [NW*AW] write addresses, port k at [k*AW +: AW]
//   wdata      : [NW*XLEN] write data, port k at [k*XLEN +: XLEN]
//   raddr      : [NR*AW] read addresses, port j at [j*AW +: AW]
//   rdata      : [NR*XLEN] read data, port j at [j*XLEN +: XLEN]
module reg_file_mp import rf_pkg::*; #(
  parameter int XLEN     = RF_XLEN,
  parameter int NREGS    = RF_NREGS,
  parameter int AW       = clog2(NREGS),
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int READ_LAT = READ_LAT_COMB,
  parameter int BYPASS   = 1,
  parameter int ZERO_R0  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [NW-1:0]        we,
  input  logic [NW*AW-1:0]     waddr,
  input  logic [NW*XLEN-1:0]   wdata,
  input  logic [NR*AW-1:0]     raddr,
  output logic [NR*XLEN-1:0]   rdata
);
  logic [NW-1:0][AW-1:0]      wa;
  logic [NW-1:0][XLEN-1:0]    wd;
  logic [NW-1:0]              wlive;
  logic [NREGS-1:0][XLEN-1:0] regs_d, regs_q;

  // A write is live only if it will actually change state this edge.
  for (genvar k = 0; k < NW; k++) begin : g_wp
    assign wa[k]    = waddr[k*AW +: AW];
    assign wd[k]    = wdata[k*XLEN +: XLEN];
    assign wlive[k] = we[k] && !clr && !((ZERO_R0 != 0) && (wa[k] == '0));
  end

  always_comb begin
    regs_d = regs_q;
    if (clr) begin
      regs_d = '0;
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (wlive[k]) regs_d[wa[k]] = wd[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  for (genvar j = 0; j < NR; j++) begin : g_rp
    rf_read_port #(
      .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NW(NW),
      .READ_LAT(READ_LAT), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)
    ) u_rp (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .wlive (wlive),
      .wa    (wa),
      .wd    (wd),
      .regs  (regs_q),
      .raddr (raddr[j*AW +: AW]),
      .rdata (rdata[j*XLEN +: XLEN])
    );
  end
endmodule
